uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8, width of one UART character (matches uart_data_t).
REQ-002 Parameter DEPTH, default 8, number of FIFO entries; SHALL be a power of 2, >= 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 wr_data  input  DATA_W  character written by the host.
REQ-006 wr_en  input  1  write request for wr_data.
REQ-007 flush  input  1  synchronous clear of FIFO contents and overflow flag.
REQ-008 tx_data  output  DATA_W  character presented to the transmitter.
REQ-009 send  output  1  one-cycle start pulse to the transmitter.
REQ-010 tx_data_ready  input  1  transmitter idle and able to accept a character.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-014 overflow  output  1  sticky: a write was dropped because the FIFO was full.

Function
REQ-015 Storage SHALL be a circular buffer with write and read pointers that wrap modulo DEPTH.
REQ-016 A write SHALL be accepted iff wr_en=1, flush=0 and full=0 (registered value); accepted data is stored and count increments next cycle.
REQ-017 wr_en=1 while full=1 SHALL drop the data, leave pointers and count unchanged, and set overflow next cycle.
REQ-018 There is no write-to-read bypass; a written entry is poppable no earlier than the cycle after the write.
REQ-019 Handshake FSM states: IDLE, SEND, WAIT_ACK, WAIT_DONE.
REQ-020 In IDLE, when empty=0 and tx_data_ready=1, the FSM SHALL pop: tx_data <= head entry, read pointer advances, and the state moves to SEND.
REQ-021 In SEND, send SHALL be 1 for exactly that cycle; the state then moves to WAIT_ACK.
REQ-022 In WAIT_ACK, the state SHALL remain until tx_data_ready=0, then move to WAIT_DONE.
REQ-023 In WAIT_DONE, the state SHALL remain until tx_data_ready=1, then move to IDLE.
REQ-024 send SHALL be 0 in all states except SEND.
REQ-025 tx_data SHALL hold its value from the pop until the next pop.
REQ-026 Latency: a write at cycle N into an empty FIFO, with FSM IDLE and tx_data_ready=1, SHALL produce a pop at N+1 and send=1 at N+2.
REQ-027 A simultaneous accepted write and pop SHALL leave count unchanged; both pointers advance.
REQ-028 A write accepted while full=1 cannot occur; a pop in the same cycle does not free space for that write.
REQ-029 flush=1 SHALL reset both pointers, count and overflow next cycle, and take priority over wr_en and any pop that cycle (no pop occurs).
REQ-030 flush SHALL NOT abort an in-flight handshake; the FSM continues from SEND, WAIT_ACK or WAIT_DONE and tx_data is unchanged.
REQ-031 full, empty and count SHALL be registered or derived from registered count, with no combinational path from wr_en.

Reset
REQ-032 With rst_n=0 at a clock edge: state=IDLE, pointers=0, count=0, empty=1, full=0, overflow=0, send=0, tx_data=0.
REQ-033 Reset asserted mid-operation SHALL discard all stored entries and abandon any handshake; send=0 from the first reset cycle.
REQ-034 Storage array contents need not be reset.

Verification
REQ-035 Single char: tx_data_ready=1, write 0x55 at cycle 0 -> pop at 1, send=1 only at 2 with tx_data=0x55, count back to 0 at 2.
REQ-036 Fill/overflow (DEPTH=8), tx_data_ready=0: 9 writes 0x00..0x08 -> full=1 after 8th, 9th dropped, overflow=1, count=8; then ready toggles -> 0x00..0x07 sent in order.
REQ-037 Handshake: after send, hold tx_data_ready=1 for 5 cycles then 0 for 10 then 1 -> no second send before the 0->1 return; next send 2 cycles after return if not empty.
REQ-038 Wrap/simultaneous: 20 chars streamed with writes each cycle while popping -> output order preserved, count never exceeds DEPTH, pointer wrap correct.
REQ-039 Flush during WAIT_DONE with count=3 -> count=0, empty=1, overflow=0 next cycle; current tx_data unchanged; no further send.
REQ-040 Reset in WAIT_ACK with count=4 -> all outputs at reset values next cycle, no send after release until a new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Character FIFO in front of a UART transmitter: circular buffer plus a
// four-state start/ack/done handshake that pops one character per transfer.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_en,
  input  logic                       flush,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       send,
  input  logic                       tx_data_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SEND      = 2'd1;
  localparam logic [1:0] WAIT_ACK  = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CW-1:0]     count_reg;
  logic              overflow_reg;
  logic [1:0]        state_reg;
  logic [1:0]        state_next;
  logic [DATA_W-1:0] tx_data_reg;

  logic wr_accept;
  logic pop;

  // Status flags come only from the registered count, so wr_en never reaches them combinationally.
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

  assign wr_accept = wr_en && !flush && !full;
  assign pop       = (state_reg == IDLE) && !empty && tx_data_ready && !flush;

  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign tx_data  = tx_data_reg;
  assign send     = (state_reg == SEND);

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (pop) state_next = SEND;
      SEND:      state_next = WAIT_ACK;
      WAIT_ACK:  if (!tx_data_ready) state_next = WAIT_DONE;
      WAIT_DONE: if (tx_data_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      tx_data_reg  <= '0;
    end else begin
      // The handshake keeps running through a flush; only the queue is cleared.
      state_reg <= state_next;
      if (flush) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (wr_accept) begin
          wr_ptr_reg <= wr_ptr_reg + PW'(1);
        end
        if (pop) begin
          rd_ptr_reg  <= rd_ptr_reg + PW'(1);
          tx_data_reg <= mem[rd_ptr_reg];
        end
        case ({wr_accept, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
        if (wr_en && full) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, latency, fill/overflow, handshake,
// streaming with wrap, flush and mid-handshake reset.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] tx_data;
  logic       send;
  logic       tx_data_ready = 1'b0;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_fifo #(.DATA_W(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
    .tx_data(tx_data), .send(send), .tx_data_ready(tx_data_ready),
    .full(full), .empty(empty), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called from the SEND cycle: ready low through WAIT_ACK, then back high to IDLE.
  task automatic finish_hs();
    tx_data_ready = 1'b0;
    tick();
    tick();
    tx_data_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_checks++; if (send !== 1'b0) begin n_fail++; $display("FAIL reset_send got %b want 0", send); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    tx_data_ready = 1'b1;
    wr_data = 8'h55;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL single_count1 got %0d want 1", count); end
    n_checks++; if (send !== 1'b0) begin n_fail++; $display("FAIL single_send_early got %b want 0", send); end
    tick();
    n_checks++; if (send !== 1'b1) begin n_fail++; $display("FAIL single_send got %b want 1", send); end
    n_checks++; if (tx_data !== 8'h55) begin n_fail++; $display("FAIL single_tx_data got %h want 55", tx_data); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL single_count0 got %0d want 0", count); end
    tick();
    n_checks++; if (send !== 1'b0) begin n_fail++; $display("FAIL single_send_one_cycle got %b want 0", send); end
    tx_data_ready = 1'b0;
    tick();
    tx_data_ready = 1'b1;
    tick();
    $display("test_single done");
  endtask

  task automatic drain_one(input logic [7:0] exp);
    bit seen = 1'b0;
    tx_data_ready = 1'b1;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick();
      if (send) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL drain_send_timeout got none want send for %h", exp); end
    n_checks++; if (tx_data !== exp) begin n_fail++; $display("FAIL drain_order got %h want %h", tx_data, exp); end
    finish_hs();
  endtask

  task automatic test_fill_overflow();
    tx_data_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_data = 8'(i);
      wr_en = 1'b1;
      tick();
      if (i == 7) begin
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %b want 1", full); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf got %b want 0", overflow); end
      end
    end
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fill_count got %0d want 8", count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow got %b want 1", overflow); end
    // Pop and write in the same cycle while full: the write must still be dropped.
    tx_data_ready = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    n_checks++; if (count !== 4'd7) begin n_fail++; $display("FAIL full_pop_write_count got %0d want 7", count); end
    n_checks++; if (send !== 1'b1 || tx_data !== 8'h00) begin n_fail++; $display("FAIL full_pop_first got send=%b data=%h want send=1 data=00", send, tx_data); end
    finish_hs();
    for (int i = 1; i < 8; i++) drain_one(8'(i));
    n_checks++; if (empty !== 1'b1 || count !== 4'd0) begin n_fail++; $display("FAIL drain_empty got empty=%b count=%0d want 1/0", empty, count); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky got %b want 1", overflow); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL flush_clears_ovf got %b want 0", overflow); end
    $display("test_fill_overflow done");
  endtask

  task automatic test_handshake();
    tx_data_ready = 1'b1;
    wr_data = 8'hA5;
    wr_en = 1'b1;
    tick();
    wr_data = 8'h3C;
    tick();
    wr_en = 1'b0;
    n_checks++; if (send !== 1'b1 || tx_data !== 8'hA5) begin n_fail++; $display("FAIL hs_first_send got send=%b data=%h want 1/a5", send, tx_data); end
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL hs_simul_count got %0d want 1", count); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (send !== 1'b0) begin n_fail++; $display("FAIL hs_ready_hi_send cycle %0d got %b want 0", i, send); end
    end
    tx_data_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (send !== 1'b0 || tx_data !== 8'hA5) begin n_fail++; $display("FAIL hs_ready_lo cycle %0d got send=%b data=%h want 0/a5", i, send, tx_data); end
    end
    tx_data_ready = 1'b1;
    tick();
    n_checks++; if (send !== 1'b0) begin n_fail++; $display("FAIL hs_return_plus1 got %b want 0", send); end
    tick();
    n_checks++; if (send !== 1'b1 || tx_data !== 8'h3C) begin n_fail++; $display("FAIL hs_second_send got send=%b data=%h want 1/3c", send, tx_data); end
    finish_hs();
    $display("test_handshake done");
  endtask

  task automatic test_back_to_back();
    int wr_idx = 0;
    int rd_idx = 0;
    int busy = 0;
    int max_count = 0;
    int cyc = 0;
    tx_data_ready = 1'b1;
    while (rd_idx < 20 && cyc < 400) begin
      if (send) begin
        n_checks++; if (tx_data !== 8'(8'h40 + rd_idx)) begin n_fail++; $display("FAIL stream_order idx %0d got %h want %h", rd_idx, tx_data, 8'(8'h40 + rd_idx)); end
        rd_idx++;
        busy = 2;
      end
      tx_data_ready = (busy == 0);
      if (busy > 0) busy--;
      n_checks++; if (count > 4'd8) begin n_fail++; $display("FAIL stream_count_bound got %0d want <=8", count); end
      if (int'(count) > max_count) max_count = int'(count);
      wr_en = (wr_idx < 20) && !full;
      wr_data = 8'(8'h40 + wr_idx);
      if (wr_en) wr_idx++;
      tick();
      cyc++;
    end
    wr_en = 1'b0;
    n_checks++; if (rd_idx !== 20) begin n_fail++; $display("FAIL stream_all_sent got %0d want 20", rd_idx); end
    n_checks++; if (max_count !== 8) begin n_fail++; $display("FAIL stream_reached_full got %0d want 8", max_count); end
    finish_hs();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL stream_end_empty got %b want 1", empty); end
    $display("test_back_to_back done");
  endtask

  task automatic test_flush();
    tx_data_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wr_data = 8'(8'h11 * i);
      wr_en = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    tx_data_ready = 1'b1;
    tick();
    n_checks++; if (send !== 1'b1 || tx_data !== 8'h11 || count !== 4'd3) begin n_fail++; $display("FAIL flush_setup got send=%b data=%h count=%0d want 1/11/3", send, tx_data, count); end
    tx_data_ready = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0) begin n_fail++; $display("FAIL flush_clear got count=%0d empty=%b ovf=%b want 0/1/0", count, empty, overflow); end
    n_checks++; if (tx_data !== 8'h11) begin n_fail++; $display("FAIL flush_tx_hold got %h want 11", tx_data); end
    tx_data_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (send !== 1'b0) begin n_fail++; $display("FAIL flush_no_send cycle %0d got %b want 0", i, send); end
    end
    // Flush in the same cycle a pop would otherwise happen.
    tx_data_ready = 1'b0;
    wr_data = 8'h77;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tx_data_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (count !== 4'd0 || tx_data !== 8'h11) begin n_fail++; $display("FAIL flush_beats_pop got count=%0d data=%h want 0/11", count, tx_data); end
    tick();
    n_checks++; if (send !== 1'b0) begin n_fail++; $display("FAIL flush_beats_pop_send got %b want 0", send); end
    $display("test_flush done");
  endtask

  task automatic test_reset_mid();
    tx_data_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wr_data = 8'(8'h60 + i);
      wr_en = 1'b1;
      tick();
    end
    tx_data_ready = 1'b1;
    wr_data = 8'h65;
    tick();
    wr_en = 1'b0;
    tick();
    n_checks++; if (count !== 4'd4 || send !== 1'b0) begin n_fail++; $display("FAIL rstmid_setup got count=%0d send=%b want 4/0", count, send); end
    rst_n = 1'b0;
    tick();
    n_checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL rstmid_status got count=%0d empty=%b full=%b want 0/1/0", count, empty, full); end
    n_checks++; if (send !== 1'b0 || tx_data !== 8'h00 || overflow !== 1'b0) begin n_fail++; $display("FAIL rstmid_outputs got send=%b data=%h ovf=%b want 0/00/0", send, tx_data, overflow); end
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (send !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_send cycle %0d got %b want 0", i, send); end
    end
    wr_data = 8'h99;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tick();
    n_checks++; if (send !== 1'b1 || tx_data !== 8'h99) begin n_fail++; $display("FAIL rstmid_new_send got send=%b data=%h want 1/99", send, tx_data); end
    finish_hs();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_handshake();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
